// File: rtl/menu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : menu_pkg
// Purpose  : Shared types and constants for the main-menu front end:
//            top-level state encodings, menu index constants, the selector
//            FSM enum and the grid-move helper.
// Ports    : none (package)
// Config   : MENU_ATTRACT_EN adds the ATTRACT state to the selector enum.
// Revision : 1.0 - initial release
// ============================================================================
package menu_pkg;

  typedef logic [3:0] top_state_t;
  typedef logic [1:0] menu_idx_t;

  // Top-level controller states
  localparam top_state_t ST_MENU        = 4'b0000;
  localparam top_state_t ST_VOLUME      = 4'b0001;
  localparam top_state_t ST_POKEMON     = 4'b0010;
  localparam top_state_t ST_FRUIT       = 4'b0011;
  localparam top_state_t ST_POTION_INIT = 4'b0100;

  // Menu grid entries, encoded as {row, col}
  localparam menu_idx_t MENU_VOLUME  = 2'b00;
  localparam menu_idx_t MENU_POKEMON = 2'b01;
  localparam menu_idx_t MENU_FRUIT   = 2'b10;
  localparam menu_idx_t MENU_POTION  = 2'b11;

`ifdef MENU_ATTRACT_EN
  typedef enum logic [1:0] {
    SEL_HOLD    = 2'd0,
    SEL_NAV     = 2'd1,
    SEL_ATTRACT = 2'd2
  } sel_state_t;
`else
  typedef enum logic [0:0] {
    SEL_HOLD = 1'b0,
    SEL_NAV  = 1'b1
  } sel_state_t;
`endif

  // One grid move with priority U > D > L > R; U/D flip the row bit,
  // L/R flip the column bit, so every move wraps by construction.
  function automatic menu_idx_t menu_move(input menu_idx_t cur,
                                          input logic up, input logic down,
                                          input logic left, input logic right);
    menu_idx_t res;
    res = cur;
    if (up || down) begin
      res[1] = ~cur[1];
    end else if (left || right) begin
      res[0] = ~cur[0];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/menu_selector_if.sv
`default_nettype none
// ============================================================================
// Module   : menu_selector_if
// Purpose  : Button / state / selection bundle between the button front end
//            (master) and the menu selector (slave).
// Signals  : btnC, btnL, btnR, btnU, btnD - single-pulse buttons
//            state          - current top-level state (0000 = menu)
//            nextStateMenu  - selected entry {row, col}
//            launch         - one-cycle launch strobe
//            cursor_blink   - 1 = draw highlight
//            attract        - high while auto-cycling
// Revision : 1.0 - initial release
// ============================================================================
interface menu_selector_if;
  import menu_pkg::*;

  logic       btnC;
  logic       btnL;
  logic       btnR;
  logic       btnU;
  logic       btnD;
  top_state_t state;
  menu_idx_t  nextStateMenu;
  logic       launch;
  logic       cursor_blink;
  logic       attract;

  modport master (
    output btnC, btnL, btnR, btnU, btnD, state,
    input  nextStateMenu, launch, cursor_blink, attract
  );

  modport slave (
    input  btnC, btnL, btnR, btnU, btnD, state,
    output nextStateMenu, launch, cursor_blink, attract
  );

endinterface
`default_nettype wire

// File: rtl/menu_timer.sv
`default_nettype none
// ============================================================================
// Module   : menu_timer
// Purpose  : Period counter with clear and enable. expire flags the terminal
//            count (LIMIT-1); an enabled count at terminal reloads to zero, so
//            expire lasts one enabled cycle and the count never wraps past it.
// Ports    : clk, reset   - clock, synchronous active-high reset
//            clear        - force count to zero (wins over enable)
//            enable       - advance the count
//            expire       - count is at LIMIT-1
// Revision : 1.0 - initial release
// ============================================================================
module menu_timer #(
  parameter int unsigned LIMIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == TERMINAL) ? '0 : count + WIDTH'(1);
    end
  end

  assign expire = (count == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/menu_selector.sv
`default_nettype none
// ============================================================================
// Module   : menu_selector
// Purpose  : Main-menu cursor and launch front end. Navigates a 2x2 grid
//            from single-pulse buttons, emits a one-cycle launch strobe
//            paired with the selection, restores the cursor to the last
//            launched entry on menu re-entry, and drives a blink flag.
// Ports    : clk   - 1 kHz button clock
//            reset - synchronous active-high reset
//            bus   - menu_selector_if.slave (buttons, state, outputs)
// Params   : IDLE_MS  - idle cycles in NAV before ATTRACT
//            CYCLE_MS - cycles per cursor step in ATTRACT
//            BLINK_MS - cycles per blink half-period
// Config   : MENU_ATTRACT_EN builds the idle/cycle timers and ATTRACT state;
//            without it attract is tied low and IDLE_MS/CYCLE_MS are inert.
// Revision : 1.0 - initial release
// ============================================================================
module menu_selector #(
  parameter int unsigned IDLE_MS  = 10000,
  parameter int unsigned CYCLE_MS = 1000,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic              clk,
  input  logic              reset,
  menu_selector_if.slave    bus
);
  import menu_pkg::*;

  sel_state_t fsm;
  sel_state_t fsm_next;
  menu_idx_t  cursor;
  menu_idx_t  cursor_next;
  menu_idx_t  last_launched;
  menu_idx_t  last_next;
  logic       launch;
  logic       launch_next;
  logic       blink;
  logic       blink_next;

  logic       btn_dir;
  logic       blink_clear;
  logic       blink_enable;
  logic       blink_expire;

  assign btn_dir = bus.btnU | bus.btnD | bus.btnL | bus.btnR;

  menu_timer #(.LIMIT(BLINK_MS)) u_blink_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (blink_clear),
    .enable (blink_enable),
    .expire (blink_expire)
  );

`ifdef MENU_ATTRACT_EN
  logic btn_any;
  logic attract;
  logic attract_next;
  logic idle_clear;
  logic idle_enable;
  logic idle_expire;
  logic cycle_clear;
  logic cycle_enable;
  logic cycle_expire;

  assign btn_any = bus.btnC | btn_dir;

  menu_timer #(.LIMIT(IDLE_MS)) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle_clear),
    .enable (idle_enable),
    .expire (idle_expire)
  );

  menu_timer #(.LIMIT(CYCLE_MS)) u_cycle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (cycle_clear),
    .enable (cycle_enable),
    .expire (cycle_expire)
  );
`else
  // Timing parameters for the absent attract feature are referenced only
  // so the parameter list stays identical between builds.
  logic unused_attract_cfg;
  assign unused_attract_cfg = IDLE_MS[0] ^ CYCLE_MS[0];
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm           <= SEL_HOLD;
      cursor        <= MENU_VOLUME;
      last_launched <= MENU_VOLUME;
      launch        <= 1'b0;
      blink         <= 1'b1;
`ifdef MENU_ATTRACT_EN
      attract       <= 1'b0;
`endif
    end else begin
      fsm           <= fsm_next;
      cursor        <= cursor_next;
      last_launched <= last_next;
      launch        <= launch_next;
      blink         <= blink_next;
`ifdef MENU_ATTRACT_EN
      attract       <= attract_next;
`endif
    end
  end

  // Next-state / next-output logic. Every timer is cleared unless the
  // current branch explicitly keeps it running, which is what discards
  // pending counts on any exit from NAV or ATTRACT.
  always_comb begin
    fsm_next     = fsm;
    cursor_next  = cursor;
    last_next    = last_launched;
    launch_next  = 1'b0;
    blink_next   = blink;
    blink_clear  = 1'b1;
    blink_enable = 1'b0;
`ifdef MENU_ATTRACT_EN
    attract_next = 1'b0;
    idle_clear   = 1'b1;
    idle_enable  = 1'b0;
    cycle_clear  = 1'b1;
    cycle_enable = 1'b0;
`endif

    if (bus.state != ST_MENU) begin
      // Outside the menu: freeze cursor and blink, suppress everything.
      fsm_next = SEL_HOLD;
    end else begin
      case (fsm)
        SEL_HOLD: begin
          fsm_next    = SEL_NAV;
          cursor_next = last_launched;
          blink_next  = 1'b1;
        end

        SEL_NAV: begin
          if (bus.btnC) begin
            // Guard keeps launch a strict single-cycle strobe even if the
            // button source misbehaves.
            launch_next  = ~launch;
            last_next    = cursor;
            blink_clear  = 1'b0;
            blink_enable = 1'b1;
            if (blink_expire) begin
              blink_next = ~blink;
            end
          end else if (btn_dir) begin
            cursor_next = menu_move(cursor, bus.btnU, bus.btnD, bus.btnL, bus.btnR);
            blink_next  = 1'b1;
          end else begin
            blink_clear  = 1'b0;
            blink_enable = 1'b1;
            if (blink_expire) begin
              blink_next = ~blink;
            end
`ifdef MENU_ATTRACT_EN
            idle_clear  = 1'b0;
            idle_enable = 1'b1;
            if (idle_expire) begin
              fsm_next     = SEL_ATTRACT;
              attract_next = 1'b1;
              blink_next   = 1'b1;
            end
`endif
          end
        end

`ifdef MENU_ATTRACT_EN
        SEL_ATTRACT: begin
          blink_next = 1'b1;
          if (btn_any) begin
            // Wake-up press is swallowed: no move, no launch.
            fsm_next = SEL_NAV;
          end else begin
            attract_next = 1'b1;
            cycle_clear  = 1'b0;
            cycle_enable = 1'b1;
            if (cycle_expire) begin
              cursor_next = cursor + 2'd1;
            end
          end
        end
`endif

        default: begin
          fsm_next = SEL_HOLD;
        end
      endcase
    end
  end

  assign bus.nextStateMenu = cursor;
  assign bus.launch        = launch;
  assign bus.cursor_blink  = blink;
`ifdef MENU_ATTRACT_EN
  assign bus.attract       = attract;
`else
  assign bus.attract       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_menu_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_selector
// Purpose  : Self-checking bench for menu_selector. A timestamp-based model
//            of the menu rules predicts every output each cycle; directed
//            sequences pin the model with literal values, then randomized
//            button/state/reset traffic runs against it.
// Config   : MENU_ATTRACT_EN enables the attract-mode sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_selector;

  localparam int unsigned IDLE  = 20;
  localparam int unsigned CYC   = 5;
  localparam int unsigned BLINK = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  menu_selector_if bus ();

  menu_selector #(
    .IDLE_MS  (IDLE),
    .CYCLE_MS (CYC),
    .BLINK_MS (BLINK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is an edge count; the blink phase, idle window and attract position
  // are derived from the edge at which each last restarted.
  localparam int M_HOLD = 0, M_NAV = 1, M_ATT = 2;
  int unsigned now = 0;
  int          mode;
  logic [1:0]  m_cursor, m_last;
  logic        m_launch, m_blink, m_attract;
  int unsigned blink_t0, idle_t0, att_t0;
  logic [1:0]  att_c0;

  always @(posedge clk) begin : model
    logic prev_launch;
    logic any_btn;
    now = now + 1;
    prev_launch = m_launch;
    m_launch = 1'b0;
    any_btn = bus.btnC | bus.btnU | bus.btnD | bus.btnL | bus.btnR;
    if (reset) begin
      mode = M_HOLD; m_cursor = 2'd0; m_last = 2'd0;
      m_blink = 1'b1; m_attract = 1'b0;
    end else if (bus.state != 4'd0) begin
      mode = M_HOLD; m_attract = 1'b0;
    end else if (mode == M_HOLD) begin
      mode = M_NAV; m_cursor = m_last; m_blink = 1'b1;
      blink_t0 = now; idle_t0 = now;
    end else if (mode == M_NAV) begin
      if (bus.btnC) begin
        m_launch = !prev_launch;
        m_last = m_cursor;
        idle_t0 = now;
        m_blink = (((now - blink_t0) / BLINK) % 2) == 0;
      end else if (any_btn) begin
        if (bus.btnU || bus.btnD) m_cursor[1] = !m_cursor[1];
        else                      m_cursor[0] = !m_cursor[0];
        m_blink = 1'b1; blink_t0 = now; idle_t0 = now;
      end else begin
`ifdef MENU_ATTRACT_EN
        if (now - idle_t0 >= IDLE) begin
          mode = M_ATT; m_attract = 1'b1; m_blink = 1'b1;
          att_t0 = now; att_c0 = m_cursor;
        end else
`endif
        m_blink = (((now - blink_t0) / BLINK) % 2) == 0;
      end
    end else begin
      if (any_btn) begin
        mode = M_NAV; m_attract = 1'b0; m_blink = 1'b1;
        blink_t0 = now; idle_t0 = now;
      end else begin
        m_cursor = 2'((att_c0 + (now - att_t0) / CYC) % 4);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_cursor",  {2'b0, bus.nextStateMenu}, {2'b0, m_cursor});
      chk("cyc_launch",  {3'b0, bus.launch},        {3'b0, m_launch});
      chk("cyc_blink",   {3'b0, bus.cursor_blink},  {3'b0, m_blink});
      chk("cyc_attract", {3'b0, bus.attract},       {3'b0, m_attract});
    end
  end

  // ---------------- stimulus ----------------
  // b = {C, U, D, L, R}
  task automatic step(input logic [4:0] b, input logic [3:0] st);
    {bus.btnC, bus.btnU, bus.btnD, bus.btnL, bus.btnR} = b;
    bus.state = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(5'b0, 4'b0);
  endtask

  localparam logic [4:0] B_C = 5'b10000, B_U = 5'b01000, B_D = 5'b00100,
                         B_L = 5'b00010, B_R = 5'b00001;

  initial begin : stim
    int unsigned hold_left;
    logic [3:0]  hold_st;
    logic        prev_c;
    logic [4:0]  b;

    reset = 1'b1;
    step(5'b0, 4'b0);
    step(5'b0, 4'b0);
    chk_on = 1'b1;
    chk("rst_cursor",  {2'b0, bus.nextStateMenu}, 4'h0);
    chk("rst_launch",  {3'b0, bus.launch},        4'h0);
    chk("rst_blink",   {3'b0, bus.cursor_blink},  4'h1);
    chk("rst_attract", {3'b0, bus.attract},       4'h0);

    reset = 1'b0;
    step(5'b0, 4'b0);                        // HOLD -> NAV
    chk("nav_entry_blink", {3'b0, bus.cursor_blink}, 4'h1);

    step(B_R, 4'b0);
    chk("btnR_cursor", {2'b0, bus.nextStateMenu}, 4'h1);
    step(5'b0, 4'b0);
    step(B_D, 4'b0);
    chk("btnD_cursor", {2'b0, bus.nextStateMenu}, 4'h3);
    step(5'b0, 4'b0);
    step(B_C, 4'b0);
    chk("launch_hi",     {3'b0, bus.launch},        4'h1);
    chk("launch_cursor", {2'b0, bus.nextStateMenu}, 4'h3);
    step(5'b0, 4'b0);
    chk("launch_lo", {3'b0, bus.launch}, 4'h0);

    step(B_L, 4'b0);
    step(B_U, 4'b0);
    chk("back_to_00", {2'b0, bus.nextStateMenu}, 4'h0);
    step(B_L, 4'b0);
    chk("wrap_L", {2'b0, bus.nextStateMenu}, 4'h1);
    step(B_U, 4'b0);
    chk("wrap_U", {2'b0, bus.nextStateMenu}, 4'h3);
    step(B_U | B_R, 4'b0);
    chk("prio_U_over_R", {2'b0, bus.nextStateMenu}, 4'h1);

    // Launch at 10, wander off, hold outside the menu, come back.
    step(B_D, 4'b0);
    step(B_L, 4'b0);
    step(B_C, 4'b0);
    step(B_R, 4'b0);
    chk("pre_hold_cursor", {2'b0, bus.nextStateMenu}, 4'h3);
    for (int i = 0; i < 50; i++) begin
      step((i % 2) ? 5'($urandom_range(31, 1)) : 5'b0, 4'b0100);
    end
    chk("hold_cursor", {2'b0, bus.nextStateMenu}, 4'h3);
    chk("hold_launch", {3'b0, bus.launch},        4'h0);
    step(5'b0, 4'b0);
    chk("restore_cursor", {2'b0, bus.nextStateMenu}, 4'h2);
    chk("restore_blink",  {3'b0, bus.cursor_blink},  4'h1);

    // Blink half-period after a move.
    step(B_R, 4'b0);
    idle(BLINK - 1);
    chk("blink_before", {3'b0, bus.cursor_blink}, 4'h1);
    idle(1);
    chk("blink_toggle", {3'b0, bus.cursor_blink}, 4'h0);

`ifdef MENU_ATTRACT_EN
    idle(IDLE - BLINK - 1);
    chk("idle_no_attract", {3'b0, bus.attract}, 4'h0);
    idle(1);
    chk("attract_rise",  {3'b0, bus.attract},        4'h1);
    chk("attract_blink", {3'b0, bus.cursor_blink},   4'h1);
    idle(CYC - 1);
    chk("attract_wait", {2'b0, bus.nextStateMenu}, 4'h3);
    idle(1);
    chk("attract_step1", {2'b0, bus.nextStateMenu}, 4'h0);
    idle(CYC);
    chk("attract_step2", {2'b0, bus.nextStateMenu}, 4'h1);
    step(B_C, 4'b0);
    chk("wake_attract", {3'b0, bus.attract},       4'h0);
    chk("wake_launch",  {3'b0, bus.launch},        4'h0);
    chk("wake_cursor",  {2'b0, bus.nextStateMenu}, 4'h1);
`else
    idle(IDLE);
    chk("no_attract", {3'b0, bus.attract},       4'h0);
    chk("no_step",    {2'b0, bus.nextStateMenu}, 4'h3);
`endif

    for (int i = 0; i < 10; i++) begin
      step((i % 2) ? 5'b0 : 5'h1f, 4'b0010);
      chk("hold_btn_launch", {3'b0, bus.launch}, 4'h0);
    end
`ifdef MENU_ATTRACT_EN
    chk("hold_btn_cursor", {2'b0, bus.nextStateMenu}, 4'h1);
    step(5'b0, 4'b0);
    idle(IDLE);
    chk("attract_again", {3'b0, bus.attract}, 4'h1);
    reset = 1'b1;
    step(5'b0, 4'b0);
    chk("att_rst_cursor",  {2'b0, bus.nextStateMenu}, 4'h0);
    chk("att_rst_attract", {3'b0, bus.attract},       4'h0);
    chk("att_rst_blink",   {3'b0, bus.cursor_blink},  4'h1);
    chk("att_rst_launch",  {3'b0, bus.launch},        4'h0);
    reset = 1'b0;
`else
    chk("hold_btn_cursor", {2'b0, bus.nextStateMenu}, 4'h3);
`endif

    // Randomized traffic: alternating busy and sparse button blocks,
    // occasional excursions out of the menu and occasional resets.
    hold_left = 0;
    hold_st   = 4'd1;
    prev_c    = 1'b0;
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 500; i++) begin
        b = 5'b0;
        if ($urandom_range(((blk % 2) != 0) ? 39 : 3) == 0) b = 5'($urandom_range(31, 1));
        if (prev_c) b[4] = 1'b0;
        prev_c = b[4];
        if (hold_left > 0) begin
          hold_left--;
        end else if ($urandom_range(199) == 0) begin
          hold_left = $urandom_range(30, 1);
          hold_st   = 4'($urandom_range(15, 1));
        end
        reset = ($urandom_range(999) == 0);
        step(b, (hold_left > 0) ? hold_st : 4'b0);
      end
    end
    reset = 1'b0;

    // Long idle stretch in the menu.
    step(B_R, 4'b0);
    idle(30000);
`ifndef MENU_ATTRACT_EN
    chk("long_idle_attract", {3'b0, bus.attract}, 4'h0);
`endif

    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
